fc_mac_ctrl: RTL
================

# fc_mac_ctrl

Sequencer for one fully-connected layer y = W·x, built around the saturating pipelined MAC datapath (`mac_part2`).
- Accepts the N-element input vector over a valid/ready stream and stores it locally.
- Addresses an external weight ROM and drives the MAC operands and its four enables.
- Captures each accumulated result (optionally ReLU-clamped) and returns the M outputs over a valid/ready stream.

## Interface
Parameters:
- M, 4, number of outputs (weight-matrix rows)
- N, 4, input-vector length (columns)
- T, 14, data width, two's complement
- P, 2, multiplier pipeline stages; the multiplier's product latency is P-1 cycles
- AW, $clog2(M*N), weight address width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- input_data  in  T  input-vector element
- input_valid  in  1  input_data valid
- input_ready  out  1  block accepts an element this cycle
- w_addr  out  AW  weight ROM address; 1-cycle synchronous read
- w_data  in  T  weight ROM data for the w_addr of the previous cycle
- mac_a  out  T  x operand to MAC
- mac_b  out  T  weight operand to MAC
- enable_mult  out  1  multiplier enable
- en_pipeline_reg  out  1  MAC product-register load
- en_acc  out  1  MAC accumulator load
- clear_acc  out  1  MAC accumulator clear
- mac_f  in  T  MAC accumulator value
- output_data  out  T  layer output element
- output_valid  out  1  output_data valid
- output_ready  in  1  downstream accepts output

## Operation
- FSM states: LOAD, COMPUTE, DRAIN, OUTPUT. Reset enters LOAD with counters n = 0 and m = 0.
- **LOAD**
  - input_ready = 1.
  - Each input_valid && input_ready beat writes x[n] and increments n.
  - The beat with n = N-1 sets n = 0 and goes to COMPUTE.
- **COMPUTE**, N cycles, n = 0..N-1
  - w_addr = m*N + n; internal x read is registered alongside.
  - In the following cycle, mac_a = x[n] and mac_b = w_data, with enable_mult = 1.
  - Enables are driven by a valid shift register of depth P+1 fed by the issue strobe:
    - en_pipeline_reg is the issue strobe delayed P cycles.
    - en_acc is the issue strobe delayed P+1 cycles.
- **DRAIN**, P+2 cycles
  - No new issues.
  - On the last cycle: output register <= f(mac_f) and clear_acc = 1 (clears the accumulator at that edge). Then go to OUTPUT.
- **OUTPUT**
  - output_valid = 1, output_data is held stable.
  - On output_ready: if m = M-1, set m = 0 and go to LOAD; else increment m and go to COMPUTE.
- Outputs are emitted in row order 0..M-1.
- A new vector is not accepted until all M outputs of the current vector are consumed.
- enable_mult, en_pipeline_reg, en_acc and clear_acc are 0 in every cycle not listed above.
- input_ready = 0 outside LOAD.
- mac_a and mac_b are don't-care when enable_mult = 0, but must not be X.
- Saturation is performed in the MAC; this block does no arithmetic beyond address generation and the optional ReLU.

## Timing
- Reset values: input_ready = 1 (LOAD), output_valid = 0, output_data = 0, w_addr = 0, mac_a = mac_b = 0, all MAC enables = 0, internal x buffer = 0.
- COMPUTE starts at cycle 0. Last issue is at cycle N-1, last en_acc at cycle N+P.
- Capture with clear_acc happens at cycle N+P+1. output_valid rises at cycle N+P+2.
- Per-row cost is N+P+2 cycles plus the OUTPUT stall, minimum 1 cycle.
- output_ready held high gives back-to-back rows: the transition from OUTPUT to COMPUTE takes a single cycle.
- Reset asserted mid-operation: all state and the valid shift register clear immediately; any partial vector is discarded.
  - This block does not drive clear_acc during reset. The MAC's own reset clears its accumulator.
- input_valid while not in LOAD is ignored; no data is lost because input_ready = 0.
- output_ready while output_valid = 0 has no effect.

## Configuration
- FC_RELU_EN defined: capture applies ReLU, so output_data = (mac_f[T-1] ? 0 : mac_f).
- FC_RELU_EN undefined: output_data = mac_f unmodified. This is the only difference.

## Test plan
- **Reset mid-COMPUTE.** reset low for 1 cycle at COMPUTE cycle 2 -> same cycle: output_valid = 0, all MAC enables = 0, input_ready = 1. A fresh vector then produces correct results.
- **Basic M=2, N=3, P=2, behavioural MAC.** x = {1,2,3}; W rows {1,1,1} and {2,0,-1}; output_ready = 1 -> outputs 6 then -1. First output_valid exactly 7 cycles after COMPUTE entry.
- **Backpressure.** Hold output_ready = 0 for 5 cycles on row 0 -> output_data stays 6 and output_valid stays 1. No COMPUTE for row 1 until the handshake; input_ready stays 0.
- **Saturation passthrough, T=14.** x = {4095,4095,4095}, W row {2,2,2} -> output 8191 (MAC saturates). With FC_RELU_EN, row {-2,-2,-2} -> 0; without it -> -8192.
- **Input stall.** input_valid toggles 1,0,1,0,1 -> exactly 3 beats stored in order; COMPUTE entered the cycle after the third beat.
- **Enable alignment.** Scoreboard en_pipeline_reg and en_acc -> exactly N pulses each per row, P and P+1 cycles after each issue. clear_acc fires exactly once per row, in the capture cycle.

Source files
------------

// File: rtl/fc_mac_ctrl.sv
// fc_mac_ctrl: sequencer for one fully-connected layer y = W*x, built
// around the saturating pipelined MAC datapath (mac_part2).
//
// The input vector is taken over a valid/ready stream into a local buffer.
// The block then walks the weight ROM one row at a time and feeds the MAC
// operands and enables. Each accumulated row result is captured and handed
// out over a second valid/ready stream, in row order 0..M-1.
//
// Build option: define FC_RELU_EN to clamp negative row results to zero
// at capture. With the macro undefined the MAC result passes through
// unmodified.
//
// Ports
//   clk             rising-edge clock
//   reset           asynchronous active-low reset
//   input_data      input-vector element (T bits)
//   input_valid     input_data valid
//   input_ready     block accepts an element this cycle (LOAD only)
//   w_addr          weight ROM address, read synchronously in 1 cycle
//   w_data          ROM data for the previous cycle's w_addr
//   mac_a, mac_b    x and weight operands to the MAC
//   enable_mult     multiplier enable
//   en_pipeline_reg MAC product-register load
//   en_acc          MAC accumulator load
//   clear_acc       MAC accumulator clear (capture cycle only)
//   mac_f           MAC accumulator value
//   output_data     layer output element, held while output_valid
//   output_valid    output_data valid
//   output_ready    downstream accepts output
module fc_mac_ctrl #(
    parameter int M  = 4,
    parameter int N  = 4,
    parameter int T  = 14,
    parameter int P  = 2,
    parameter int AW = $clog2(M * N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [T-1:0]  input_data,
    input  logic          input_valid,
    output logic          input_ready,
    output logic [AW-1:0] w_addr,
    input  logic [T-1:0]  w_data,
    output logic [T-1:0]  mac_a,
    output logic [T-1:0]  mac_b,
    output logic          enable_mult,
    output logic          en_pipeline_reg,
    output logic          en_acc,
    output logic          clear_acc,
    input  logic [T-1:0]  mac_f,
    output logic [T-1:0]  output_data,
    output logic          output_valid,
    input  logic          output_ready
);

    localparam int NW = (N > 1) ? $clog2(N) : 1;
    localparam int MW = (M > 1) ? $clog2(M) : 1;
    localparam int DW = $clog2(P + 2);
    localparam logic [AW-1:0] ROW_STRIDE = AW'(N);

    typedef enum logic [1:0] {
        LOAD,
        COMPUTE,
        DRAIN,
        OUTPUT
    } state_t;

    state_t state, state_nx;

    logic [NW-1:0] n;
    logic [MW-1:0] m;
    logic [DW-1:0] d;
    logic [T-1:0]  xbuf [N];
    logic [T-1:0]  x_q;
    logic [P:0]    vsr;
    logic [T-1:0]  out_q;
    logic [T-1:0]  cap_val;

    logic n_last, m_last, d_last;
    logic beat, issue, capture;

    assign n_last  = (n == NW'(N - 1));
    assign m_last  = (m == MW'(M - 1));
    assign d_last  = (d == DW'(P + 1));
    assign beat    = (state == LOAD) && input_valid;
    assign issue   = (state == COMPUTE);
    assign capture = (state == DRAIN) && d_last;

`ifdef FC_RELU_EN
    assign cap_val = mac_f[T-1] ? '0 : mac_f;
`else
    assign cap_val = mac_f;
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= LOAD;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            LOAD:    if (beat && n_last) state_nx = COMPUTE;
            COMPUTE: if (n_last) state_nx = DRAIN;
            DRAIN:   if (d_last) state_nx = OUTPUT;
            OUTPUT:  if (output_ready) state_nx = m_last ? LOAD : COMPUTE;
            default: state_nx = LOAD;
        endcase
    end

    // Output logic. Operands are forced to zero whenever the multiplier is
    // idle so the MAC never sees X from an unread ROM word.
    always_comb begin
        input_ready     = (state == LOAD);
        output_valid    = (state == OUTPUT);
        output_data     = out_q;
        w_addr          = '0;
        if (issue) begin
            w_addr = AW'(m) * ROW_STRIDE + AW'(n);
        end
        enable_mult     = vsr[0];
        en_pipeline_reg = vsr[P-1];
        en_acc          = vsr[P];
        clear_acc       = capture;
        mac_a           = vsr[0] ? x_q : '0;
        mac_b           = vsr[0] ? w_data : '0;
    end

    // Element, row and drain counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            n <= '0;
            m <= '0;
            d <= '0;
        end else begin
            case (state)
                LOAD:    if (beat) n <= n_last ? '0 : n + NW'(1);
                COMPUTE: n <= n_last ? '0 : n + NW'(1);
                DRAIN:   d <= d_last ? '0 : d + DW'(1);
                OUTPUT:  if (output_ready) m <= m_last ? '0 : m + MW'(1);
                default: ;
            endcase
        end
    end

    // Input-vector buffer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < N; i++) begin
                xbuf[i] <= '0;
            end
        end else if (beat) begin
            xbuf[n] <= input_data;
        end
    end

    // The x read is registered so it lines up with the 1-cycle ROM read.
    // vsr[k] is the issue strobe delayed k+1 cycles; bit 0 doubles as the
    // multiplier enable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q   <= '0;
            vsr   <= '0;
            out_q <= '0;
        end else begin
            if (issue) begin
                x_q <= xbuf[n];
            end
            vsr <= {vsr[P-1:0], issue};
            if (capture) begin
                out_q <= cap_val;
            end
        end
    end

endmodule
